// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes
// big-endian 32-bit words into instruction memory, holding the CPU in reset until done.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [15:0]     DEPTH_W = 16'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_s;
    logic [7:0]        len_hi_r;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       asm_r;
    logic [7:0]        csum_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    logic              xfer_s;
    logic [15:0]       len_full_s;
    logic [ADDR_W:0]   last_idx_s;
    logic              word_end_s;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign xfer_s     = rx_valid & rx_ready;
    assign len_full_s = {len_hi_r, rx_data};
    assign last_idx_s = n_r - ONE_W;
    assign word_end_s = (byte_cnt_r == 2'd3);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = ST_LEN_HI;
            ST_LEN_HI: begin
                if (xfer_s) begin
                    state_s = ST_LEN_LO;
                end else begin
                    state_s = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (!xfer_s) begin
                    state_s = ST_LEN_LO;
                end else if (len_full_s > DEPTH_W) begin
                    state_s = ST_ERROR;
                end else if (len_full_s == 16'd0) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_s && word_end_s && (word_idx_r == last_idx_s)) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (!xfer_s) begin
                    state_s = ST_CHECK;
                end else if (rx_data == csum_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            ST_DONE:   state_s = ST_DONE;
            ST_ERROR:  state_s = ST_ERROR;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Length capture, word assembly, checksum and write-port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_r   <= 8'd0;
            n_r        <= '0;
            word_idx_r <= '0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
            csum_r     <= 8'd0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
        end else begin
            we_r <= 1'b0;
            if (xfer_s) begin
                case (state_r)
                    ST_LEN_HI: len_hi_r <= rx_data;
                    ST_LEN_LO: begin
                        // Only the low bits matter once N has passed the DEPTH check.
                        n_r        <= len_full_s[ADDR_W:0];
                        word_idx_r <= '0;
                        byte_cnt_r <= 2'd0;
                    end
                    ST_DATA: begin
                        asm_r      <= {asm_r[15:0], rx_data};
                        csum_r     <= csum_next(csum_r, rx_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (word_end_s) begin
                            wdata_r    <= {asm_r, rx_data};
                            addr_r     <= word_idx_r[ADDR_W-1:0];
                            we_r       <= 1'b1;
                            word_idx_r <= word_idx_r + ONE_W;
                        end else begin
                            word_idx_r <= word_idx_r;
                        end
                    end
                    default: begin
                        len_hi_r <= len_hi_r;
                    end
                endcase
            end else begin
                len_hi_r <= len_hi_r;
            end
        end
    end

    assign rx_ready   = (state_r == ST_LEN_HI) || (state_r == ST_LEN_LO) ||
                        (state_r == ST_DATA)   || (state_r == ST_CHECK);
    assign cpu_reset  = (state_r != ST_DONE);
    assign done       = (state_r == ST_DONE);
    assign error      = (state_r == ST_ERROR);
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: streams are scored against a
// reference model that parses the image format directly.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]        stream[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    logic              exp_done;
    logic              exp_err;
    logic              exp_we_next;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
    end

    // Reference model: parse the image and predict writes and final verdict.
    task automatic run_model();
        int n;
        logic [7:0] cs;
        exp_addr.delete();
        exp_data.delete();
        n  = {stream[0], stream[1]};
        cs = 8'd0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(w[ADDR_W-1:0]);
                exp_data.push_back({stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
                for (int k = 0; k < 4; k++) cs = cs ^ stream[2+4*w+k];
            end
            exp_done = (stream[2+4*n] == cs);
            exp_err  = !exp_done;
        end
    endtask

    task automatic build_stream(input int n, input bit good_cs);
        logic [7:0] cs;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        cs = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            cs = cs ^ b;
        end
        if (good_cs) stream.push_back(cs);
        else stream.push_back(cs ^ 8'($urandom_range(255, 1)));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive the first 'limit' bytes of the stream with random gaps; check write
    // timing every cycle and, for a full stream, the writes and final verdict.
    task automatic drive_stream(input int max_gap, input int limit);
        int  n;
        int  p;
        int  waits;
        int  gaps;
        bit  abort;
        bit  accepted;
        n = {stream[0], stream[1]};
        p = 0;
        abort = 1'b0;
        exp_we_next = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        while (p < limit && !abort) begin
            gaps = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                total++;
                if (imem_we !== exp_we_next) begin
                    bad++;
                    $display("FAIL we_timing gap p=%0d got=%b want=%b", p, imem_we, exp_we_next);
                end
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk);
                exp_we_next = 1'b0;
            end
            waits = 0;
            accepted = 1'b0;
            while (!accepted && !abort) begin
                @(negedge clk);
                total++;
                if (imem_we !== exp_we_next) begin
                    bad++;
                    $display("FAIL we_timing p=%0d got=%b want=%b", p, imem_we, exp_we_next);
                end
                rx_valid = 1'b1;
                rx_data  = stream[p];
                accepted = (rx_ready === 1'b1);
                @(posedge clk);
                exp_we_next = accepted && (n <= DEPTH) && (p >= 2) && (p < 2 + 4 * n) &&
                              (((p - 2) % 4) == 3);
                if (accepted) p++;
                else begin
                    waits++;
                    if (waits > 8) abort = 1'b1;
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (imem_we !== exp_we_next) begin
            bad++;
            $display("FAIL we_timing end got=%b want=%b", imem_we, exp_we_next);
        end
        if (limit >= stream.size()) begin
            run_model();
            total++;
            if (done !== exp_done || error !== exp_err || cpu_reset !== !exp_done) begin
                bad++;
                $display("FAIL verdict got done=%b err=%b cpu_reset=%b want done=%b err=%b",
                         done, error, cpu_reset, exp_done, exp_err);
            end
            repeat (3) @(negedge clk);
            total++;
            if (rx_ready !== 1'b0 || done !== exp_done || error !== exp_err) begin
                bad++;
                $display("FAIL terminal got rdy=%b done=%b err=%b", rx_ready, done, error);
            end
            total++;
            if (obs_data.size() != exp_data.size()) begin
                bad++;
                $display("FAIL write_count got=%0d want=%0d", obs_data.size(), exp_data.size());
            end
            for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
                total++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL write[%0d] got=%0d:%h want=%0d:%h", i, obs_addr[i], obs_data[i],
                             exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total++;
        if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 ||
            cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL reset_values rdy=%b we=%b addr=%0d wd=%h cr=%b d=%b e=%b",
                     rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [31:0] words[3];
        logic [7:0]  cs;
        words[0] = 32'h20080005;
        words[1] = 32'h2009000C;
        words[2] = 32'hAC080004;
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h03);
        cs = 8'h00;
        for (int w = 0; w < 3; w++)
            for (int k = 3; k >= 0; k--) begin
                stream.push_back(words[w][8*k +: 8]);
                cs = cs ^ words[w][8*k +: 8];
            end
        stream.push_back(cs);
        drive_stream(0, stream.size());
        total++;
        if (obs_data.size() != 3 || done !== 1'b1) begin
            bad++;
            $display("FAIL basic writes=%0d done=%b want 3 and 1", obs_data.size(), done);
        end
        for (int i = 0; i < obs_data.size() && i < 3; i++) begin
            total++;
            if (obs_data[i] !== words[i] || obs_addr[i] !== ADDR_W'(i)) begin
                bad++;
                $display("FAIL basic_word[%0d] got=%h want=%h", i, obs_data[i], words[i]);
            end
        end
        apply_reset();
    endtask

    task automatic test_zero_len();
        stream = '{8'h00, 8'h00, 8'h00};
        drive_stream(0, stream.size());
        total++;
        if (done !== 1'b1 || obs_data.size() != 0) begin
            bad++;
            $display("FAIL zero_ok done=%b writes=%0d want 1 0", done, obs_data.size());
        end
        apply_reset();
        stream = '{8'h00, 8'h00, 8'h01};
        drive_stream(0, stream.size());
        total++;
        if (error !== 1'b1 || cpu_reset !== 1'b1) begin
            bad++;
            $display("FAIL zero_bad err=%b cpu_reset=%b want 1 1", error, cpu_reset);
        end
        apply_reset();
    endtask

    task automatic test_length_bounds();
        stream = '{8'h00, 8'h41, 8'h11, 8'h22, 8'h33};
        drive_stream(2, stream.size());
        total++;
        if (error !== 1'b1 || rx_ready !== 1'b0 || obs_data.size() != 0) begin
            bad++;
            $display("FAIL overflow err=%b rdy=%b writes=%0d want 1 0 0", error, rx_ready, obs_data.size());
        end
        apply_reset();
        build_stream(DEPTH, 1'b1);
        drive_stream(0, stream.size());
        total++;
        if (done !== 1'b1 || obs_data.size() != DEPTH) begin
            bad++;
            $display("FAIL full_depth done=%b writes=%0d want 1 %0d", done, obs_data.size(), DEPTH);
        end
        apply_reset();
    endtask

    task automatic test_bad_checksum();
        build_stream(2, 1'b0);
        drive_stream(0, stream.size());
        total++;
        if (obs_data.size() != 2 || error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            bad++;
            $display("FAIL bad_cs writes=%0d err=%b done=%b cr=%b", obs_data.size(), error, done, cpu_reset);
        end
        apply_reset();
    endtask

    task automatic test_gaps();
        logic [31:0] ref_data[$];
        build_stream(2, 1'b1);
        drive_stream(0, stream.size());
        ref_data = obs_data;
        apply_reset();
        drive_stream(5, stream.size());
        total++;
        if (obs_data != ref_data || done !== 1'b1) begin
            bad++;
            $display("FAIL gaps writes=%0d ref=%0d done=%b", obs_data.size(), ref_data.size(), done);
        end
        apply_reset();
    endtask

    task automatic test_reset_midload();
        build_stream(2, 1'b1);
        drive_stream(0, 8);
        total++;
        if (obs_data.size() != 1) begin
            bad++;
            $display("FAIL midload_writes got=%0d want=1", obs_data.size());
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 ||
            cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL midload_reset rdy=%b we=%b addr=%0d wd=%h cr=%b d=%b e=%b",
                     rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stream = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_stream(0, stream.size());
        total++;
        if (done !== 1'b1 || obs_data.size() != 1) begin
            bad++;
            $display("FAIL after_reset_load done=%b writes=%0d", done, obs_data.size());
        end
        apply_reset();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            build_stream($urandom_range(8, 1), ($urandom_range(3, 0) != 0));
            drive_stream($urandom_range(3, 0), stream.size());
            apply_reset();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_length_bounds();
        test_bad_checksum();
        test_gaps();
        test_reset_midload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
